alu_mc: RTL and testbench

Parametrised multi-cycle execute-stage ALU: next generation of the 16-bit combinational ALU, generalised to WIDTH bits with registered result and flags, a valid/ready handshake, and an iterative shift-add multiplier. Sits in the execute stage after the operand-forwarding muxes, which stay upstream; it stalls the pipeline through `in_ready` while a multiply is in flight. The `{C,N,Z}` flag register lives inside the block, including restore-from-stack (pop) loading.

---
 rtl/alu_mc_if.sv | 31 +++
 rtl/alu_mc.sv | 188 ++++++++++++++++++
 tb/tb_alu_mc.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle execute ALU.
//   master modport (pipeline side): drives in_valid, alu_op, op1, op2, carry_sel,
//     flag_wr, flag_src, flags_pop; observes in_ready, out_valid, result, flags, busy.
//   slave modport (alu_mc side): the mirror image.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [1:0]       carry_sel;
  logic             flag_wr;
  logic             flag_src;
  logic [2:0]       flags_pop;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;
  logic             busy;

  modport master (
    output in_valid, alu_op, op1, op2, carry_sel, flag_wr, flag_src, flags_pop,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, alu_op, op1, op2, carry_sel, flag_wr, flag_src, flags_pop,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU with registered result and {C,N,Z} flag register.
// Single-cycle ops complete on the accept edge; MUL (only when ALU_MUL_EN is
// defined) is an iterative shift-add taking WIDTH further cycles, during which
// in_ready is low and new requests are ignored.
// Ports: clk, rst (async, active-high), bus (alu_mc_if.slave: handshake,
// opcode, operands, carry/flag controls, result, flags, out_valid, busy).
// Build macro: ALU_MUL_EN enables the multiplier.
//
// state  | meaning
// IDLE   | accepting; non-MUL ops complete on the accept edge
// MUL    | one shift-add per cycle, completes when counter reaches 0
module alu_mc #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input logic clk,
  input logic rst,
  alu_mc_if.slave bus
);
  localparam logic [3:0] OP_NOT = 4'b0000;
  localparam logic [3:0] OP_INC = 4'b0001;
  localparam logic [3:0] OP_DEC = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;

  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  logic [SHAMT_W-1:0] amt;
  logic [WIDTH:0]     ext_add, ext_sub, ext_inc, ext_dec, ext_shl, ext_shr;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;

  assign amt     = bus.op2[SHAMT_W-1:0];
  assign ext_add = {1'b0, bus.op1} + {1'b0, bus.op2};
  assign ext_sub = {1'b0, bus.op1} - {1'b0, bus.op2};
  assign ext_inc = {1'b0, bus.op1} + (WIDTH+1)'(1);
  assign ext_dec = {1'b0, bus.op1} - (WIDTH+1)'(1);
  assign ext_shl = {1'b0, bus.op1} << amt;
  // Appending a zero LSB lets bit 0 of the shifted value be op1[amt-1].
  assign ext_shr = {bus.op1, 1'b0} >> amt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (bus.alu_op)
      OP_NOT: alu_res = ~bus.op1;
      OP_INC: {alu_c, alu_res} = ext_inc;
      OP_DEC: {alu_c, alu_res} = ext_dec;
      OP_ADD: {alu_c, alu_res} = ext_add;
      OP_SUB: {alu_c, alu_res} = ext_sub;
      OP_AND: alu_res = bus.op1 & bus.op2;
      OP_OR:  alu_res = bus.op1 | bus.op2;
      OP_SHL: {alu_c, alu_res} = ext_shl;
      OP_SHR: begin
        alu_res = ext_shr[WIDTH:1];
        alu_c   = ext_shr[0];
      end
      default: ;
    endcase
  end

  function automatic logic [2:0] calc_flags(
    input logic [WIDTH-1:0] res,
    input logic             c_alu,
    input logic [1:0]       csel,
    input logic             fwr,
    input logic             fsrc,
    input logic [2:0]       pop,
    input logic [2:0]       cur
  );
    logic c;
    if (!fwr) return cur;
    if (fsrc) return pop;
    case (csel)
      2'b00:   c = c_alu;
      2'b01:   c = 1'b1;
      2'b10:   c = 1'b0;
      default: c = cur[2];
    endcase
    return {c, res[WIDTH-1], (res == '0)};
  endfunction

`ifdef ALU_MUL_EN
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam int         CNT_W  = $clog2(WIDTH);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     step_sum;
  // Controls captured at accept: {carry_sel, flag_wr, flag_src, flags_pop}
  logic [6:0]         ctl_q, ctl_d;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {step_sum, prod_q[WIDTH-1:1]};

  assign bus.busy     = (state_q == S_MUL);
  assign bus.in_ready = (state_q == S_IDLE);
`else
  assign bus.busy     = 1'b0;
  assign bus.in_ready = 1'b1;
`endif

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    ctl_d   = ctl_q;
    if (state_q == S_MUL) begin
      prod_d = prod_step;
      if (cnt_q == '0) begin
        state_d     = S_IDLE;
        result_d    = prod_step[WIDTH-1:0];
        flags_d     = calc_flags(prod_step[WIDTH-1:0], |prod_step[2*WIDTH-1:WIDTH],
                                 ctl_q[6:5], ctl_q[4], ctl_q[3], ctl_q[2:0], flags_q);
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (accept && bus.alu_op == OP_MUL) begin
      state_d = S_MUL;
      cnt_d   = CNT_W'(WIDTH-1);
      prod_d  = {{WIDTH{1'b0}}, bus.op2};
      mcand_d = bus.op1;
      ctl_d   = {bus.carry_sel, bus.flag_wr, bus.flag_src, bus.flags_pop};
    end else
`endif
    // Single-cycle path (the else-branch above when the multiplier is built).
    if (accept) begin
      result_d    = alu_res;
      flags_d     = calc_flags(alu_res, alu_c, bus.carry_sel, bus.flag_wr,
                               bus.flag_src, bus.flags_pop, flags_q);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      ctl_q   <= ctl_d;
    end
  end
`endif

  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W), .SHAMT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [1:0]   cs;
    logic         fw, fs;
    logic [2:0]   pop;
    logic [W-1:0] er;
    logic [2:0]   ef;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic [2:0]   f;
    int           due;
    int           tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   tag_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk($sformatf("result#%0d", e.tag), 32'(bus.result), 32'(e.r));
        chk($sformatf("flags#%0d", e.tag), 32'(bus.flags), 32'(e.f));
        chk($sformatf("latency#%0d", e.tag), cyc, e.due);
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] cs, input logic fw, input logic fs,
                              input logic [2:0] pop, input logic [W-1:0] er, input logic [2:0] ef);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cs = cs; v.fw = fw; v.fs = fs;
    v.pop = pop; v.er = er; v.ef = ef;
    return v;
  endfunction

  task automatic issue(input vec_t v, input int lat);
    exp_t e;
    @(negedge clk);
    chk("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.alu_op    = v.op;
    bus.op1       = v.a;
    bus.op2       = v.b;
    bus.carry_sel = v.cs;
    bus.flag_wr   = v.fw;
    bus.flag_src  = v.fs;
    bus.flags_pop = v.pop;
    e.r = v.er; e.f = v.ef; e.due = cyc + lat; e.tag = tag_n;
    tag_n++;
    sbq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0; bus.alu_op = '0; bus.op1 = '0; bus.op2 = '0;
    bus.carry_sel = '0; bus.flag_wr = 1'b0; bus.flag_src = 1'b0; bus.flags_pop = '0;

    //         op      op1      op2      cs     fw    fs    pop     result   {C,N,Z}
    vecs.push_back(mk(4'h3, 16'hFFFF, 16'h0001, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 3'b101));
    vecs.push_back(mk(4'h4, 16'h0003, 16'h0005, 2'b00, 1'b1, 1'b0, 3'b000, 16'hFFFE, 3'b110));
    vecs.push_back(mk(4'h8, 16'h8001, 16'h0001, 2'b00, 1'b1, 1'b0, 3'b000, 16'h4000, 3'b100));
    vecs.push_back(mk(4'h7, 16'h8001, 16'h0010, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 3'b101));
    vecs.push_back(mk(4'h0, 16'h00FF, 16'h1234, 2'b00, 1'b1, 1'b0, 3'b000, 16'hFF00, 3'b010));
    vecs.push_back(mk(4'h1, 16'h7FFF, 16'h0000, 2'b00, 1'b1, 1'b0, 3'b000, 16'h8000, 3'b010));
    vecs.push_back(mk(4'h2, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 3'b000, 16'hFFFF, 3'b110));
    vecs.push_back(mk(4'h5, 16'hF0F0, 16'h0FF0, 2'b01, 1'b1, 1'b0, 3'b000, 16'h00F0, 3'b100));
    vecs.push_back(mk(4'h3, 16'h0001, 16'h0001, 2'b11, 1'b1, 1'b0, 3'b000, 16'h0002, 3'b100));
    vecs.push_back(mk(4'h6, 16'h1200, 16'h0034, 2'b10, 1'b1, 1'b0, 3'b000, 16'h1234, 3'b000));
    vecs.push_back(mk(4'h7, 16'h0001, 16'h0014, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 3'b001));
    vecs.push_back(mk(4'h8, 16'h8000, 16'h0010, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 3'b101));
    vecs.push_back(mk(4'h8, 16'h0001, 16'h0000, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0001, 3'b000));
    vecs.push_back(mk(4'hF, 16'hAA55, 16'h1234, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 3'b001));
    vecs.push_back(mk(4'h7, 16'h0003, 16'h0021, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0006, 3'b000));
    vecs.push_back(mk(4'h5, 16'hF0F0, 16'h0F0F, 2'b01, 1'b1, 1'b1, 3'b101, 16'h0000, 3'b101));
    vecs.push_back(mk(4'h3, 16'h1111, 16'h2222, 2'b00, 1'b0, 1'b0, 3'b000, 16'h3333, 3'b101));
    vecs.push_back(mk(4'h4, 16'h8000, 16'h0001, 2'b01, 1'b0, 1'b1, 3'b010, 16'h7FFF, 3'b101));
`ifndef ALU_MUL_EN
    // Without the multiplier, 1001 behaves as a reserved single-cycle op.
    vecs.push_back(mk(4'h9, 16'h0100, 16'h0100, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 3'b001));
`endif

    // Reset state
    @(negedge clk);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Back-to-back single-cycle vectors
    foreach (vecs[i]) issue(vecs[i], 1);
    idle();
    repeat (2) @(negedge clk);

`ifdef ALU_MUL_EN
    // MUL 0x0100 x 0x0100 with ignored in_valid pulses while busy
    issue(mk(4'h9, 16'h0100, 16'h0100, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 3'b101), W);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_%0d", i), 32'(bus.busy), 32'd1);
      chk($sformatf("mul_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
      bus.in_valid = (i % 3 == 1) && (i < W - 1);
      bus.alu_op   = 4'h3;
      bus.op1      = 16'h1234;
      bus.op2      = 16'h4321;
      bus.flag_wr  = 1'b1;
    end
    @(negedge clk);
    chk("mul_done_busy", 32'(bus.busy), 32'd0);
    chk("mul_done_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back accept right after completion, then more products
    issue(mk(4'h9, 16'h0003, 16'h0005, 2'b00, 1'b1, 1'b0, 3'b000, 16'h000F, 3'b000), W);
    idle();
    repeat (W) @(negedge clk);
    issue(mk(4'h9, 16'hFFFF, 16'hFFFF, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0001, 3'b100), W);
    idle();
    repeat (W) @(negedge clk);
    issue(mk(4'h9, 16'h00F0, 16'h0010, 2'b01, 1'b0, 1'b0, 3'b000, 16'h0F00, 3'b100), W);
    idle();
    repeat (W) @(negedge clk);

    // Leave a nonzero result/flags, then reset in the middle of a MUL
    issue(mk(4'h3, 16'h1111, 16'h2222, 2'b01, 1'b1, 1'b0, 3'b000, 16'h3333, 3'b100), 1);
    issue(mk(4'h9, 16'h0100, 16'h0100, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 3'b101), W);
    idle();
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midmul_rst_result", 32'(bus.result), 32'd0);
    chk("midmul_rst_flags", 32'(bus.flags), 32'd0);
    chk("midmul_rst_busy", 32'(bus.busy), 32'd0);
    chk("midmul_rst_in_ready", 32'(bus.in_ready), 32'd1);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("post_rst_result", 32'(bus.result), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
`else
    // Leave a nonzero result/flags, then reset asynchronously mid-cycle
    issue(mk(4'h3, 16'h1111, 16'h2222, 2'b01, 1'b1, 1'b0, 3'b000, 16'h3333, 3'b100), 1);
    idle();
    chk("nomul_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", 32'(bus.result), 32'd0);
    chk("async_rst_flags", 32'(bus.flags), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
`endif

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
